sha256_msg_padder: RTL

- Producer for the SHA-256 compression core's 512-bit message-block input.
- Absorbs an arbitrary-length byte stream (one byte per cycle, valid/ready handshake, last marker).
- Applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit big-endian bit length.
- Emits one or more 512-bit blocks over a valid/ready handshake, tagged first/final so the core knows when to load the IV and when the digest is complete.

---
 rtl/sha256_pkg.sv | 15 +
 rtl/sha256_msg_padder_if.sv | 25 ++
 rtl/sha256_msg_padder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  typedef enum logic [1:0] {
    ABSORB,
    PAD,
    LEN,
    EMIT
  } pad_state_t;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_POS     = 56;
  localparam logic [7:0] PAD_MARKER  = 8'h80;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and 512-bit block output of the padder.
// master = the padder itself, slave = its producer/consumer environment.
interface sha256_msg_padder_if;

  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_final;

  modport master (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_final
  );

  modport slave (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_final
  );

endinterface

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder feeding 512-bit blocks to a SHA-256 core.
// Optional: define SHA_PAD_FAST_FILL_EN to complete the zero fill in one PAD cycle.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input logic                 clk,
  input logic                 reset,
  sha256_msg_padder_if.master bus
);

  pad_state_t       state_q, state_d;
  pad_state_t       resume_q, resume_d;
  logic [5:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d;
  logic             marker_done_q, marker_done_d;
  logic             final_q, final_d;
  logic [7:0]       blk_buf_q [BLOCK_BYTES];
  logic [7:0]       blk_buf_d [BLOCK_BYTES];

  logic             accept;
  logic [63:0]      len_field;
  logic [511:0]     blk_flat;

  assign accept    = bus.in_valid && bus.in_ready;
  assign len_field = 64'(len_q);

`ifdef SHA_PAD_FAST_FILL_EN
  // Marker landing past the length slot forces the fill to run to the block end.
  logic fill_to_end;
  assign fill_to_end = (ptr_q >= 6'(LEN_POS));
`endif

  // NOTE: the buffer is reset here so an aborted message can never leak into a later block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ABSORB;
      resume_q      <= ABSORB;
      ptr_q         <= '0;
      len_q         <= '0;
      first_q       <= 1'b1;
      marker_done_q <= 1'b0;
      final_q       <= 1'b0;
      for (int i = 0; i < BLOCK_BYTES; i++) blk_buf_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q       <= state_d;
      resume_q      <= resume_d;
      ptr_q         <= ptr_d;
      len_q         <= len_d;
      first_q       <= first_d;
      marker_done_q <= marker_done_d;
      final_q       <= final_d;
      blk_buf_q     <= blk_buf_d;
    end
  end

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    resume_d      = resume_q;
    ptr_d         = ptr_q;
    len_d         = len_q;
    first_d       = first_q;
    marker_done_d = marker_done_q;
    final_d       = final_q;
    blk_buf_d     = blk_buf_q;

    unique case (state_q)
      ABSORB: begin
        if (accept) begin
          blk_buf_d[ptr_q] = bus.in_data;
          ptr_d            = ptr_q + 6'd1;
          len_d            = len_q + LEN_W'(8);
          if (ptr_q == 6'(BLOCK_BYTES - 1)) begin
            state_d  = EMIT;
            final_d  = 1'b0;
            resume_d = bus.in_last ? PAD : ABSORB;
          end else if (bus.in_last) begin
            state_d = PAD;
          end
        end
      end

      PAD: begin
        if (marker_done_q && ptr_q == 6'(LEN_POS)) begin
          state_d = LEN;
        end else begin
`ifdef SHA_PAD_FAST_FILL_EN
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i >= int'(ptr_q) && i <= (fill_to_end ? BLOCK_BYTES - 1 : LEN_POS - 1)) begin
              blk_buf_d[i] = (i == int'(ptr_q) && !marker_done_q) ? PAD_MARKER : 8'h00;
            end
          end
          marker_done_d = 1'b1;
          if (fill_to_end) begin
            state_d  = EMIT;
            final_d  = 1'b0;
            resume_d = PAD;
            ptr_d    = '0;
          end else begin
            state_d = LEN;
            ptr_d   = 6'(LEN_POS);
          end
`else
          blk_buf_d[ptr_q] = marker_done_q ? 8'h00 : PAD_MARKER;
          marker_done_d    = 1'b1;
          ptr_d            = ptr_q + 6'd1;
          if (ptr_q == 6'(BLOCK_BYTES - 1)) begin
            state_d  = EMIT;
            final_d  = 1'b0;
            resume_d = PAD;
          end else if (ptr_q == 6'(LEN_POS - 1)) begin
            // Last fill byte written: go straight to the length without an idle cycle.
            state_d = LEN;
          end
`endif
        end
      end

      LEN: begin
        for (int k = 0; k < 8; k++) blk_buf_d[LEN_POS + k] = len_field[63 - 8*k -: 8];
        state_d = EMIT;
        final_d = 1'b1;
      end

      EMIT: begin
        if (bus.blk_ready) begin
          ptr_d = '0;
          if (final_q) begin
            first_d       = 1'b1;
            len_d         = '0;
            marker_done_d = 1'b0;
            state_d       = ABSORB;
          end else begin
            first_d = 1'b0;
            state_d = resume_q;
          end
        end
      end

      default: state_d = ABSORB;
    endcase
  end

  always_comb begin
    blk_flat = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) blk_flat[511 - 8*i -: 8] = blk_buf_q[i];
  end

  assign bus.in_ready  = !reset && (state_q == ABSORB);
  assign bus.blk_valid = !reset && (state_q == EMIT);
  assign bus.blk_first = bus.blk_valid && first_q;
  assign bus.blk_final = bus.blk_valid && final_q;
  assign bus.blk_data  = blk_flat;

endmodule
